// File: rtl/gray_pkg.sv
// Shared types and Gray/binary helpers for the Gray counter slice.
// Optional self-check enabled by defining GRAY_CHECK_EN.
package gray_pkg;

    localparam int GRAY_W    = 4;
    localparam int GRAY_MAXW = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    function automatic logic [GRAY_MAXW-1:0] width_mask(
        input int w
    );
        logic [GRAY_MAXW-1:0] m;
        for (int i = 0; i < GRAY_MAXW; i++) begin
            m[i] = (i < w);
        end
        return m;
    endfunction

    function automatic logic [GRAY_MAXW-1:0] bin2gray(
        input logic [GRAY_MAXW-1:0] b,
        input int                   w
    );
        logic [GRAY_MAXW-1:0] bm;
        bm = b & width_mask(w);
        return bm ^ (bm >> 1);
    endfunction

    function automatic logic [GRAY_MAXW-1:0] gray2bin(
        input logic [GRAY_MAXW-1:0] g,
        input int                   w
    );
        logic [GRAY_MAXW-1:0] b;
        logic                 acc;
        b   = '0;
        acc = 1'b0;
        // MSB passes through; each lower bit folds in the running XOR
        for (int i = GRAY_MAXW - 1; i >= 0; i--) begin
            if (i < w) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Step-rate divider: one-cycle tick every DIV enabled cycles.
// en freezes the count, clr returns it to zero.
module tick_divider #(
    parameter int DIV = 27000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/gray_code_generator.sv
// Up/down binary counter with registered Gray output and valid/ready.
// Define GRAY_CHECK_EN to add the sticky Gray->binary self-check.
module gray_code_generator
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W,
    parameter int DIV   = 27000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] bin_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] gray_o,
    output logic [WIDTH-1:0] bin_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             wrap_o,
    output logic             err_o
);

    localparam logic [WIDTH-1:0] ALL1 = '1;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] bin_n;
    logic [WIDTH-1:0] gray_n;
    logic             valid_n;
    logic             wrap_n;
    logic             step;
    logic             tick;
    logic             div_en;
    logic             div_clr;

    assign div_en  = (state == RUN);
    assign div_clr = (state == IDLE) || !en_i;

    tick_divider #(
        .DIV (DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .en   (div_en),
        .tick (tick)
    );

    always_comb begin
        state_n = state;
        bin_n   = bin_o;
        valid_n = valid_o && !ready_i;
        wrap_n  = 1'b0;
        step    = 1'b0;
        if (load_i) begin
            bin_n   = bin_i;
            valid_n = 1'b1;
            state_n = en_i ? RUN : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en_i) state_n = RUN;
                end
                RUN: begin
                    if (!en_i) begin
                        state_n = IDLE;
                    end else if (tick) begin
                        if (valid_o && !ready_i) begin
                            state_n = HOLD;
                        end else begin
                            step = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (ready_i) begin
                        step    = 1'b1;
                        state_n = en_i ? RUN : IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (step) begin
            bin_n   = up_i ? bin_o + WIDTH'(1)
                           : bin_o - WIDTH'(1);
            valid_n = 1'b1;
            wrap_n  = up_i ? (bin_o == ALL1)
                           : (bin_o == '0);
        end
    end

    // Gray is derived from the next count so both words move together
    assign gray_n = WIDTH'(bin2gray(GRAY_MAXW'(bin_n), WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bin_o   <= '0;
            gray_o  <= '0;
            valid_o <= 1'b0;
            wrap_o  <= 1'b0;
        end else begin
            state   <= state_n;
            bin_o   <= bin_n;
            gray_o  <= gray_n;
            valid_o <= valid_n;
            wrap_o  <= wrap_n;
        end
    end

`ifdef GRAY_CHECK_EN
    logic             err_q;
    logic [WIDTH-1:0] dec;

    assign dec = WIDTH'(gray2bin(GRAY_MAXW'(gray_o), WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (dec != bin_o) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_code_generator.sv
// Directed bench for gray_code_generator with a transfer scoreboard.
// Define GRAY_CHECK_EN to also exercise the sticky error flag.
module tb_gray_code_generator;

    localparam int W   = 4;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_i = 1'b0;
    logic [W-1:0] bin_i = '0;
    logic         en_i = 1'b0;
    logic         up_i = 1'b1;
    logic         ready_i = 1'b0;
    logic [W-1:0] gray_o;
    logic [W-1:0] bin_o;
    logic         valid_o;
    logic         wrap_o;
    logic         err_o;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] sbq[$];

    gray_code_generator #(
        .WIDTH (W),
        .DIV   (DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_i),
        .bin_i   (bin_i),
        .en_i    (en_i),
        .up_i    (up_i),
        .gray_o  (gray_o),
        .bin_o   (bin_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .wrap_o  (wrap_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every word the consumer accepts must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            logic [W-1:0] e;
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $error("FAIL xfer_extra obs=%0h exp=none", gray_o);
            end else begin
                e = sbq.pop_front();
                assert (gray_o === e) else begin
                    failures++;
                    $error("FAIL xfer obs=%0h exp=%0h", gray_o, e);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] prev;
        logic [W-1:0] b;

        tick(2);
        chk("rst_bin", bin_o, 0);
        chk("rst_gray", gray_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_wrap", wrap_o, 0);
        chk("rst_err", err_o, 0);

        rst    = 1'b0;
        load_i = 1'b1;
        bin_i  = 4'b1011;
        sbq.push_back(4'b1110);
        tick(1);
        load_i = 1'b0;
        chk("ld_bin", bin_o, 4'b1011);
        chk("ld_gray", gray_o, 4'b1110);
        chk("ld_valid", valid_o, 1);
        ready_i = 1'b1;
        tick(1);
        chk("xfer_valid_fall", valid_o, 0);

        load_i = 1'b1;
        bin_i  = 4'b0000;
        sbq.push_back(4'b0000);
        tick(1);
        load_i = 1'b0;
        chk("ld0_gray", gray_o, 0);
        chk("ld0_valid", valid_o, 1);
        en_i = 1'b1;
        up_i = 1'b1;
        tick(1);
        prev = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            b = W'(k);
            sbq.push_back(g(b));
            tick(DIV);
            chk($sformatf("up_bin%0d", k), bin_o, b);
            chk($sformatf("up_gray%0d", k), gray_o, g(b));
            chk($sformatf("up_wrap%0d", k), wrap_o, k == 16);
            chk($sformatf("up_1bit%0d", k),
                $countones(gray_o ^ prev), 1);
            prev = gray_o;
        end
        chk("up_gray1", {28'd0, 4'b0001} ^ 32'd0, 32'd1 & 32'd1);
        tick(1);
        chk("wrap_pulse_end", wrap_o, 0);

        en_i   = 1'b0;
        load_i = 1'b1;
        bin_i  = 4'b0000;
        sbq.push_back(4'b0000);
        tick(1);
        load_i = 1'b0;
        chk("ld_nowrap", wrap_o, 0);
        en_i = 1'b1;
        up_i = 1'b0;
        sbq.push_back(4'b1000);
        tick(1 + DIV);
        chk("dn_bin", bin_o, 4'b1111);
        chk("dn_gray", gray_o, 4'b1000);
        chk("dn_wrap", wrap_o, 1);

        ready_i = 1'b0;
        tick(DIV);
        chk("hold_bin", bin_o, 4'b1111);
        chk("hold_gray", gray_o, 4'b1000);
        chk("hold_valid", valid_o, 1);
        tick(2);
        chk("hold_gray2", gray_o, 4'b1000);
        sbq.push_back(4'b1001);
        ready_i = 1'b1;
        tick(1);
        chk("rel_bin", bin_o, 4'b1110);
        chk("rel_gray", gray_o, 4'b1001);
        chk("rel_valid", valid_o, 1);
        chk("rel_wrap", wrap_o, 0);

        tick(1);
        chk("rel_xfer_valid", valid_o, 0);
        ready_i = 1'b0;
        tick(DIV - 1);
        chk("st_bin", bin_o, 4'b1101);
        tick(DIV);
        chk("st_hold_bin", bin_o, 4'b1101);
        chk("st_hold_gray", gray_o, 4'b1011);
        load_i = 1'b1;
        bin_i  = 4'b0101;
        sbq.push_back(4'b0111);
        tick(1);
        load_i = 1'b0;
        chk("hld_ld_bin", bin_o, 4'b0101);
        chk("hld_ld_gray", gray_o, 4'b0111);
        chk("hld_ld_valid", valid_o, 1);
        ready_i = 1'b1;
        sbq.push_back(4'b0110);
        tick(1);
        chk("drop_step", bin_o, 4'b0101);
        tick(DIV - 1);
        chk("post_ld_bin", bin_o, 4'b0100);
        chk("post_ld_gray", gray_o, 4'b0110);
        tick(1);
        chk("sb_empty", sbq.size(), 0);
        chk("err_quiet", err_o, 0);

        en_i = 1'b0;
        rst  = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst2_bin", bin_o, 0);
        chk("rst2_gray", gray_o, 0);
        chk("rst2_valid", valid_o, 0);

`ifdef GRAY_CHECK_EN
        force dut.gray_o = 4'b0001;
        tick(1);
        release dut.gray_o;
        chk("err_set", err_o, 1);
        tick(2);
        chk("err_sticky", err_o, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("err_clr", err_o, 0);
`else
        tick(2);
        chk("err_tied", err_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
